mem_cmd_capture: RTL and testbench
==================================

# mem_cmd_capture

Front-end stage for the block-RAM exerciser. It synchronizes and debounces the board pushbutton and, on each clean press, samples the slide switches (port select, read/write select, address, data) into one registered command. The command is offered to the downstream memory-control FSM over a valid/ready handshake. The block replaces raw button/switch wiring into that FSM so each press produces exactly one memory operation.

## Interface

- DATA_WIDTH, 4, width of data switches and cmdData
- ADDR_WIDTH, 4, width of address switches and cmdAddr
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change (≥2)
- CNT_WIDTH, 18, debounce counter width; must hold DEBOUNCE_CYCLES
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- buttonIn  input  1  raw pushbutton, active-low (0 = pressed), asynchronous
- portSwitch  input  1  0 = port A, 1 = port B
- rwSwitch  input  1  0 = read, 1 = write
- addrSwitches  input  ADDR_WIDTH  raw address switches
- dataSwitches  input  DATA_WIDTH  raw write-data switches
- cmdReady  input  1  downstream accepts command this cycle
- cmdValid  output  1  command pending
- cmdPort  output  1  captured portSwitch
- cmdWrite  output  1  captured rwSwitch
- cmdAddr  output  ADDR_WIDTH  captured address
- cmdData  output  DATA_WIDTH  captured data
- dropCount  output  4  presses discarded while a command was pending, saturating

## Operation

- Synchronizer: buttonIn and all switch inputs pass through two flops (sync1, sync2); reset value of button flops 1, switch flops 0.
- Debouncer: register stableLevel (reset 1) and counter (reset 0). Each edge: if sync2 == stableLevel, counter ← 0; else if counter == DEBOUNCE_CYCLES−1, stableLevel ← sync2 and counter ← 0; else counter ← counter+1.
- Press event: the edge at which stableLevel goes 1→0. Release (0→1) produces no event.
- FSM states: IDLE (cmdValid=0), PENDING (cmdValid=1).
  - IDLE + press: capture synchronized switches into cmdPort/cmdWrite/cmdAddr/cmdData; → PENDING.
  - PENDING + cmdReady: handshake completes at this edge; → IDLE. cmd fields retain last values.
  - PENDING + press (with or without cmdReady same edge): press discarded; dropCount ← dropCount+1, saturating at 15.
  - IDLE + no press: hold.
- cmd fields change only on capture; stable throughout PENDING.
- cmdReady while IDLE is ignored.

## Timing

- Reset values: cmdValid 0, cmdPort 0, cmdWrite 0, cmdAddr 0, cmdData 0, dropCount 0, state IDLE.
- Reset asserted mid-operation: pending command discarded immediately (asynchronous), debounce restarts from released; a button still held at release of reset produces a press after the full debounce latency.
- Latency: buttonIn low before edge 0 and held → sync2 low after edge 1 → cmdValid high after edge DEBOUNCE_CYCLES+1. Switches captured are their sync2 values at that edge (i.e. sampled 2 edges earlier).
- Any cycle with sync2 back at stableLevel restarts the count; glitches shorter than DEBOUNCE_CYCLES never produce an event.
- cmdValid falls after the first edge at which cmdValid and cmdReady are both 1; minimum PENDING duration 1 cycle.
- Back-to-back commands separated by at least one full release/press debounce (≥2·DEBOUNCE_CYCLES cycles).

## Test plan

- DEBOUNCE_CYCLES=4; reset, then buttonIn=0 held from before edge 0 with portSwitch=1, rwSwitch=1, addrSwitches=4'hA, dataSwitches=4'h5 → cmdValid=1 after edge 5 with cmdPort=1, cmdWrite=1, cmdAddr=A, cmdData=5; dropCount=0.
- Bounce: buttonIn low 3 cycles, high 1, low 3, high → cmdValid stays 0; then low held 6 cycles → exactly one command.
- Handshake: cmdValid=1, cmdReady held 0 for 10 cycles → outputs unchanged; cmdReady=1 one cycle → cmdValid=0 next edge, cmdAddr unchanged.
- Drop: while PENDING, release and press again (full debounce each), twice → no new capture, dropCount=2; 20 presses → dropCount=15.
- Simultaneous: press event on same edge as cmdReady=1 in PENDING → state IDLE, cmdValid=0, dropCount+1, fields unchanged.
- Reset mid-PENDING: reset=0 for one cycle while cmdValid=1 → cmdValid=0, all fields 0, dropCount 0 immediately; button held throughout → new command DEBOUNCE_CYCLES+2 edges after reset release.

Source files
------------

// File: rtl/mem_cmd_capture.sv
// Pushbutton synchronizer/debouncer that turns each clean press into one registered
// memory command. The command is held on a valid/ready handshake until downstream accepts it.
module mem_cmd_capture #(
  parameter int unsigned DATA_WIDTH      = 4,
  parameter int unsigned ADDR_WIDTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_WIDTH       = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buttonIn,
  input  logic                  portSwitch,
  input  logic                  rwSwitch,
  input  logic [ADDR_WIDTH-1:0] addrSwitches,
  input  logic [DATA_WIDTH-1:0] dataSwitches,
  input  logic                  cmdReady,
  output logic                  cmdValid,
  output logic                  cmdPort,
  output logic                  cmdWrite,
  output logic [ADDR_WIDTH-1:0] cmdAddr,
  output logic [DATA_WIDTH-1:0] cmdData,
  output logic [3:0]            dropCount
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam int unsigned          SwWidth = 2 + ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntMax  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                  btn_sync1_q, btn_sync2_q;
  logic [SwWidth-1:0]    sw_sync1_q, sw_sync2_q;
  logic                  stable_q, stable_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  press;
  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            drop_q, drop_d;

  // Debouncer: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press    = 1'b0;
    if (btn_sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = btn_sync2_q;
      cnt_d    = '0;
      press    = stable_q;  // only the 1->0 transition is a press
    end else begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = drop_q;
    case (state_q)
      StIdle: begin
        if (press) begin
          state_d                            = StPending;
          {port_d, write_d, addr_d, data_d} = sw_sync2_q;
        end
      end
      StPending: begin
        if (cmdReady) state_d = StIdle;
        if (press && (drop_q != 4'hF)) drop_d = drop_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync1_q <= 1'b1;
      btn_sync2_q <= 1'b1;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      stable_q    <= 1'b1;
      cnt_q       <= '0;
      state_q     <= StIdle;
      port_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      drop_q      <= '0;
    end else begin
      btn_sync1_q <= buttonIn;
      btn_sync2_q <= btn_sync1_q;
      sw_sync1_q  <= {portSwitch, rwSwitch, addrSwitches, dataSwitches};
      sw_sync2_q  <= sw_sync1_q;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      port_q      <= port_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
    end
  end

  assign cmdValid  = (state_q == StPending);
  assign cmdPort   = port_q;
  assign cmdWrite  = write_q;
  assign cmdAddr   = addr_q;
  assign cmdData   = data_q;
  assign dropCount = drop_q;

endmodule

// File: tb/tb_mem_cmd_capture.sv
// Bench for mem_cmd_capture: directed vector table, hand-written corner sequences and
// randomized stimulus checked cycle-by-cycle against a sample-window reference model.
module tb_mem_cmd_capture;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DB = 4;
  localparam int CW = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          buttonIn = 1'b1;
  logic          portSwitch = 1'b0;
  logic          rwSwitch = 1'b0;
  logic [AW-1:0] addrSwitches = '0;
  logic [DW-1:0] dataSwitches = '0;
  logic          cmdReady = 1'b0;
  logic          cmdValid, cmdPort, cmdWrite;
  logic [AW-1:0] cmdAddr;
  logic [DW-1:0] cmdData;
  logic [3:0]    dropCount;

  mem_cmd_capture #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .buttonIn    (buttonIn),
    .portSwitch  (portSwitch),
    .rwSwitch    (rwSwitch),
    .addrSwitches(addrSwitches),
    .dataSwitches(dataSwitches),
    .cmdReady    (cmdReady),
    .cmdValid    (cmdValid),
    .cmdPort     (cmdPort),
    .cmdWrite    (cmdWrite),
    .cmdAddr     (cmdAddr),
    .cmdData     (cmdData),
    .dropCount   (dropCount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: raw samples delayed by two edges, then a window of the last DB
  // delayed samples since the last accepted change decides the debounced level.
  typedef struct packed {
    logic          btn;
    logic          port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } in_t;

  in_t           raw_q[$];
  logic          m_win[$];
  logic          m_stable;
  logic          m_valid, m_port, m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_drop;

  function automatic void m_reset();
    raw_q.delete();
    m_win.delete();
    m_stable = 1'b1;
    m_valid  = 1'b0;
    m_port   = 1'b0;
    m_write  = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_drop   = 0;
  endfunction

  function automatic void m_step(in_t cur, logic rst_n, logic rdy);
    in_t  s2;
    logic press;
    logic all_diff;
    if (!rst_n) begin
      m_reset();
      return;
    end
    s2 = '0;
    s2.btn = 1'b1;
    if (raw_q.size() == 2) s2 = raw_q[0];
    raw_q.push_back(cur);
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    press = 1'b0;
    m_win.push_back(s2.btn);
    if (m_win.size() > DB) void'(m_win.pop_front());
    if (m_win.size() == DB) begin
      all_diff = 1'b1;
      foreach (m_win[i]) if (m_win[i] == m_stable) all_diff = 1'b0;
      if (all_diff) begin
        press    = m_stable;
        m_stable = ~m_stable;
        m_win.delete();
      end
    end
    if (m_valid) begin
      if (press) m_drop = (m_drop < 15) ? m_drop + 1 : 15;
      if (rdy) m_valid = 1'b0;
    end else if (press) begin
      m_valid = 1'b1;
      m_port  = s2.port;
      m_write = s2.rw;
      m_addr  = s2.addr;
      m_data  = s2.data;
    end
  endfunction

  task automatic chk_model();
    chk("model_valid", cmdValid, m_valid);
    chk("model_port", cmdPort, m_port);
    chk("model_write", cmdWrite, m_write);
    chk("model_addr", cmdAddr, m_addr);
    chk("model_data", cmdData, m_data);
    chk("model_drop", dropCount, m_drop);
  endtask

  task automatic tick();
    in_t  cur;
    logic r, rdy;
    cur = '{btn: buttonIn, port: portSwitch, rw: rwSwitch, addr: addrSwitches,
            data: dataSwitches};
    r   = reset;
    rdy = cmdReady;
    @(posedge clk);
    m_step(cur, r, rdy);
    #1;
    chk_model();
  endtask

  task automatic cycle_press(int n_high, int n_low);
    buttonIn = 1'b1;
    repeat (n_high) tick();
    buttonIn = 1'b0;
    repeat (n_low) tick();
  endtask

  typedef struct {
    logic          btn, rdy, port, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          ev, ep, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic btn, logic rdy, logic port, logic rw,
                              logic [AW-1:0] addr, logic [DW-1:0] data, logic ev,
                              logic ep, logic ew, logic [AW-1:0] ea, logic [DW-1:0] ed);
    vec_t v;
    v = '{btn: btn, rdy: rdy, port: port, rw: rw, addr: addr, data: data,
          ev: ev, ep: ep, ew: ew, ea: ea, ed: ed};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  initial begin
    m_reset();
    // Latency: capture after edge DB+1 with the first switch set.
    add(5,  0, 0, 1, 1, 4'hA, 4'h5, 0, 0, 0, 4'h0, 4'h0);
    add(2,  0, 0, 1, 1, 4'hA, 4'h5, 1, 1, 1, 4'hA, 4'h5);
    // Handshake: hold then accept.
    add(10, 0, 0, 1, 1, 4'hA, 4'h5, 1, 1, 1, 4'hA, 4'h5);
    add(1,  0, 1, 1, 1, 4'hA, 4'h5, 0, 1, 1, 4'hA, 4'h5);
    // Release, then bounce that must not register.
    add(8,  1, 0, 0, 0, 4'h3, 4'hC, 0, 1, 1, 4'hA, 4'h5);
    add(3,  0, 0, 0, 0, 4'h3, 4'hC, 0, 1, 1, 4'hA, 4'h5);
    add(1,  1, 0, 0, 0, 4'h3, 4'hC, 0, 1, 1, 4'hA, 4'h5);
    add(3,  0, 0, 0, 0, 4'h3, 4'hC, 0, 1, 1, 4'hA, 4'h5);
    add(6,  1, 0, 0, 0, 4'h3, 4'hC, 0, 1, 1, 4'hA, 4'h5);
    // Clean press: exactly one command with the second switch set.
    add(5,  0, 0, 0, 0, 4'h3, 4'hC, 0, 1, 1, 4'hA, 4'h5);
    add(1,  0, 0, 0, 0, 4'h3, 4'hC, 1, 0, 0, 4'h3, 4'hC);
    add(3,  0, 0, 0, 0, 4'h3, 4'hC, 1, 0, 0, 4'h3, 4'hC);
    add(1,  0, 1, 0, 0, 4'h3, 4'hC, 0, 0, 0, 4'h3, 4'hC);
    add(5,  0, 0, 0, 0, 4'h3, 4'hC, 0, 0, 0, 4'h3, 4'hC);

    repeat (2) tick();
    chk("rst_valid", cmdValid, 1'b0);
    chk("rst_port", cmdPort, 1'b0);
    chk("rst_write", cmdWrite, 1'b0);
    chk("rst_addr", cmdAddr, 4'h0);
    chk("rst_data", cmdData, 4'h0);
    chk("rst_drop", dropCount, 4'h0);

    buttonIn = vecs[0].btn;
    portSwitch = vecs[0].port;
    rwSwitch = vecs[0].rw;
    addrSwitches = vecs[0].addr;
    dataSwitches = vecs[0].data;
    reset = 1'b1;

    foreach (vecs[i]) begin
      buttonIn     = vecs[i].btn;
      cmdReady     = vecs[i].rdy;
      portSwitch   = vecs[i].port;
      rwSwitch     = vecs[i].rw;
      addrSwitches = vecs[i].addr;
      dataSwitches = vecs[i].data;
      tick();
      chk($sformatf("tbl%0d_valid", i), cmdValid, vecs[i].ev);
      chk($sformatf("tbl%0d_port", i), cmdPort, vecs[i].ep);
      chk($sformatf("tbl%0d_write", i), cmdWrite, vecs[i].ew);
      chk($sformatf("tbl%0d_addr", i), cmdAddr, vecs[i].ea);
      chk($sformatf("tbl%0d_data", i), cmdData, vecs[i].ed);
      chk($sformatf("tbl%0d_drop", i), dropCount, 4'h0);
    end
    cmdReady = 1'b0;

    // Drops while pending must not recapture.
    {portSwitch, rwSwitch, addrSwitches, dataSwitches} = {1'b1, 1'b0, 4'h7, 4'h9};
    cycle_press(8, 8);
    chk("drop_cap_valid", cmdValid, 1'b1);
    chk("drop_cap_addr", cmdAddr, 4'h7);
    {portSwitch, rwSwitch, addrSwitches, dataSwitches} = {1'b0, 1'b1, 4'hE, 4'h2};
    cycle_press(8, 8);
    cycle_press(8, 8);
    chk("drop2_count", dropCount, 4'd2);
    chk("drop2_valid", cmdValid, 1'b1);
    chk("drop2_addr", cmdAddr, 4'h7);
    chk("drop2_data", cmdData, 4'h9);
    chk("drop2_port", cmdPort, 1'b1);

    // Press on the same edge as the accepting handshake.
    cycle_press(8, 5);
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
    chk("simul_valid", cmdValid, 1'b0);
    chk("simul_drop", dropCount, 4'd3);
    chk("simul_addr", cmdAddr, 4'h7);
    chk("simul_write", cmdWrite, 1'b0);
    repeat (2) tick();
    chk("simul_idle", cmdValid, 1'b0);

    // One capture plus 18 drops saturates the counter.
    repeat (19) cycle_press(8, 8);
    chk("sat_drop", dropCount, 4'hF);
    chk("sat_valid", cmdValid, 1'b1);
    chk("sat_addr", cmdAddr, 4'hE);

    // Asynchronous reset while pending, button held low throughout.
    reset = 1'b0;
    #1;
    m_reset();
    chk("arst_valid", cmdValid, 1'b0);
    chk("arst_addr", cmdAddr, 4'h0);
    chk("arst_data", cmdData, 4'h0);
    chk("arst_port", cmdPort, 1'b0);
    chk("arst_write", cmdWrite, 1'b0);
    chk("arst_drop", dropCount, 4'h0);
    tick();
    reset = 1'b1;
    repeat (DB + 1) tick();
    chk("arst_pre_valid", cmdValid, 1'b0);
    tick();
    chk("arst_post_valid", cmdValid, 1'b1);
    chk("arst_post_addr", cmdAddr, 4'hE);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) buttonIn = ~buttonIn;
      cmdReady     = ($urandom_range(0, 3) == 0);
      portSwitch   = 1'($urandom);
      rwSwitch     = 1'($urandom);
      addrSwitches = AW'($urandom);
      dataSwitches = DW'($urandom);
      reset        = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
